dnu_iter_rqst_ctrl: RTL

- Initiator side of the DNU IB-map update handshake.
- Per decoding iteration, raises iter_rqst toward the DNU write FSM and tracks its 2-bit busy status through the ack, load-complete and release phases.
- Counts completed updates, ends decoding on success, abort or MAX_ITER, then holds iter_termination.
- Sits in the decoding process control, between the layer scheduler and the DNU write unit; both sides run on write_clk.

---
 rtl/dnu_iter_rqst_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/dnu_iter_rqst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dnu_iter_rqst_ctrl
// Brief    : Initiator of the DNU IB-map update handshake; one request per
//            decoding iteration, terminates on success, abort, limit or timeout.
// Revision : 1.0 - initial release
// ============================================================================
module dnu_iter_rqst_ctrl #(
    parameter int MAX_ITER      = 10,
    parameter int ITER_WIDTH    = 4,
    parameter int TIMEOUT_CYCLE = 256
) (
    input  logic                  write_clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  iter_ready,
    input  logic                  decode_success,
    input  logic                  abort,
    input  logic [1:0]            wr_busy,
    output logic                  iter_rqst,
    output logic                  iter_termination,
    output logic [ITER_WIDTH-1:0] iter_cnt,
    output logic                  update_done,
    output logic                  decode_done,
    output logic                  decode_fail,
    output logic                  timeout_err,
    output logic [2:0]            ctrl_state
);

    localparam int TMR_WIDTH = (TIMEOUT_CYCLE > 2) ? $clog2(TIMEOUT_CYCLE) : 1;

    localparam logic [TMR_WIDTH-1:0]  c_TMR_LAST    = TMR_WIDTH'(TIMEOUT_CYCLE - 1);
    localparam logic [TMR_WIDTH-1:0]  c_TMR_ONE     = TMR_WIDTH'(1);
    localparam logic [ITER_WIDTH-1:0] c_ITER_MAX    = ITER_WIDTH'(MAX_ITER);
    localparam logic [ITER_WIDTH-1:0] c_ITER_ONE    = ITER_WIDTH'(1);
    localparam logic [1:0]            c_WR_IDLE     = 2'b00;
    localparam logic [1:0]            c_WR_UPDATING = 2'b01;
    localparam logic [1:0]            c_WR_FINISHED = 2'b10;

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        REQ       = 3'b001,
        LOAD      = 3'b010,
        RELEASE   = 3'b011,
        CHECK     = 3'b100,
        WAIT_ITER = 3'b101,
        TERM      = 3'b110,
        DONE      = 3'b111
    } state_t;

    state_t                r_state;
    logic [TMR_WIDTH-1:0]  r_timer;
    logic                  r_abort_flag;

    logic w_in_handshake;
    logic w_tmr_expired;

    assign w_in_handshake = (r_state == REQ) || (r_state == LOAD) || (r_state == RELEASE);
    assign w_tmr_expired  = (r_timer == c_TMR_LAST);
    assign ctrl_state     = r_state;

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            r_state          <= IDLE;
            r_timer          <= '0;
            r_abort_flag     <= 1'b0;
            iter_rqst        <= 1'b0;
            iter_termination <= 1'b0;
            iter_cnt         <= '0;
            update_done      <= 1'b0;
            decode_done      <= 1'b0;
            decode_fail      <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            update_done <= 1'b0;
            decode_done <= 1'b0;

            // Abort is only remembered here; it is acted on at CHECK or WAIT_ITER.
            if (abort && (r_state != IDLE)) begin
                r_abort_flag <= 1'b1;
            end

            if (w_in_handshake) begin
                r_timer <= r_timer + c_TMR_ONE;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state      <= REQ;
                        r_timer      <= '0;
                        r_abort_flag <= 1'b0;
                        iter_rqst    <= 1'b1;
                        iter_cnt     <= '0;
                        decode_fail  <= 1'b0;
                        timeout_err  <= 1'b0;
                    end
                end

                REQ: begin
                    if (wr_busy == c_WR_UPDATING) begin
                        r_state <= LOAD;
                    end else if (w_tmr_expired) begin
                        r_state          <= TERM;
                        iter_rqst        <= 1'b0;
                        iter_termination <= 1'b1;
                        timeout_err      <= 1'b1;
                        decode_fail      <= 1'b1;
                    end
                end

                // Request stays high so the writer parks in FINISH until we drop it.
                LOAD: begin
                    if (wr_busy == c_WR_FINISHED) begin
                        r_state   <= RELEASE;
                        iter_rqst <= 1'b0;
                    end else if (w_tmr_expired) begin
                        r_state          <= TERM;
                        iter_rqst        <= 1'b0;
                        iter_termination <= 1'b1;
                        timeout_err      <= 1'b1;
                        decode_fail      <= 1'b1;
                    end
                end

                RELEASE: begin
                    if (wr_busy == c_WR_IDLE) begin
                        r_state     <= CHECK;
                        update_done <= 1'b1;
                        if (iter_cnt < c_ITER_MAX) begin
                            iter_cnt <= iter_cnt + c_ITER_ONE;
                        end
                    end else if (w_tmr_expired) begin
                        r_state          <= TERM;
                        iter_termination <= 1'b1;
                        timeout_err      <= 1'b1;
                        decode_fail      <= 1'b1;
                    end
                end

                CHECK: begin
                    if (r_abort_flag) begin
                        r_state          <= TERM;
                        iter_termination <= 1'b1;
                        decode_fail      <= 1'b1;
                    end else if (decode_success) begin
                        r_state          <= TERM;
                        iter_termination <= 1'b1;
                        decode_fail      <= 1'b0;
                    end else if (iter_cnt >= c_ITER_MAX) begin
                        r_state          <= TERM;
                        iter_termination <= 1'b1;
                        decode_fail      <= 1'b1;
                    end else begin
                        r_state <= WAIT_ITER;
                    end
                end

                WAIT_ITER: begin
                    if (abort || r_abort_flag) begin
                        r_state          <= TERM;
                        iter_termination <= 1'b1;
                        decode_fail      <= 1'b1;
                    end else if (iter_ready) begin
                        r_state   <= REQ;
                        r_timer   <= '0;
                        iter_rqst <= 1'b1;
                    end
                end

                TERM: begin
                    r_state     <= DONE;
                    decode_done <= 1'b1;
                end

                DONE: begin
                    if (start) begin
                        r_state          <= REQ;
                        r_timer          <= '0;
                        r_abort_flag     <= 1'b0;
                        iter_rqst        <= 1'b1;
                        iter_termination <= 1'b0;
                        iter_cnt         <= '0;
                        decode_fail      <= 1'b0;
                        timeout_err      <= 1'b0;
                    end
                end

                default: begin
                    r_state          <= IDLE;
                    iter_rqst        <= 1'b0;
                    iter_termination <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
